// File: rtl/sys_reset_seq_pkg.sv
// sys_reset_seq shared types: state encoding, widths and default timings.
// Imported by the interface, lock_sync user and the sequencer top.
package sys_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILISE = 3'd2,
    SDRAM_UP  = 3'd3,
    RUN       = 3'd4,
    SOFT_RST  = 3'd5
  } state_t;

  localparam int RETRY_W = 8;

  localparam int DEF_PLL_RST_CYCLES       = 16;
  localparam int DEF_STABLE_CYCLES        = 1024;
  localparam int DEF_SDRAM_TO_CORE_CYCLES = 32;
  localparam int DEF_LOCK_TIMEOUT_CYCLES  = 65536;

  // Counter width: clog2 of the largest cycle count, plus one.
  function automatic int cnt_w(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sys_reset_seq_if.sv
// Sequencer status/reset bundle between the sequencer (master)
// and the PLL / SDRAM / core side (slave).
interface sys_reset_seq_if;
  import sys_reset_pkg::*;

  logic               pll_locked;
  logic               soft_reset_req;
  logic               pll_rst;
  logic               sdram_reset;
  logic               sys_reset;
  logic               reset_done;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  pll_locked,
    input  soft_reset_req,
    output pll_rst,
    output sdram_reset,
    output sys_reset,
    output reset_done,
    output retry_count
  );

  modport slave (
    output pll_locked,
    output soft_reset_req,
    input  pll_rst,
    input  sdram_reset,
    input  sys_reset,
    input  reset_done,
    input  retry_count
  );

endinterface

// File: rtl/sys_reset_seq_lock_sync.sv
// lock_sync: 2-flop synchroniser for an async status input,
// async active-high reset to 0.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sys_reset_seq.sv
// sys_reset_seq: PLL / SDRAM / core reset sequencer on the board refclk.
// Optional lock-timeout retry: define SYS_RESET_SEQ_LOCK_TIMEOUT_EN.
module sys_reset_seq
  import sys_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES       = DEF_PLL_RST_CYCLES,
  parameter int STABLE_CYCLES        = DEF_STABLE_CYCLES,
  parameter int SDRAM_TO_CORE_CYCLES = DEF_SDRAM_TO_CORE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES  = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  sys_reset_seq_if.master bus
);

  localparam int CW = cnt_w(PLL_RST_CYCLES, STABLE_CYCLES,
                            SDRAM_TO_CORE_CYCLES,
                            LOCK_TIMEOUT_CYCLES);

  localparam logic [CW-1:0] PLL_END = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] S2C_END = CW'(SDRAM_TO_CORE_CYCLES - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          lk;
  logic          timeout;

  logic pll_n, sd_n, sys_n, done_n;
  logic pll_q, sd_q, sys_q, done_q;

  lock_sync u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (bus.pll_locked),
    .q   (lk)
  );

`ifdef SYS_RESET_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] TO_END = CW'(LOCK_TIMEOUT_CYCLES - 1);

  logic [RETRY_W-1:0] retry;

  assign timeout = (state == WAIT_LOCK) && !lk && (cnt == TO_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry <= '0;
    end else if (timeout && (retry != '1)) begin
      retry <= retry + 1'b1;
    end
  end

  assign bus.retry_count = retry;
`else
  assign timeout         = 1'b0;
  assign bus.retry_count = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= PLL_RST;
      cnt    <= '0;
      pll_q  <= 1'b1;
      sd_q   <= 1'b1;
      sys_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= (nxt != state) ? '0 : cnt + 1'b1;
      pll_q  <= pll_n;
      sd_q   <= sd_n;
      sys_q  <= sys_n;
      done_q <= done_n;
    end
  end

  // Lock loss is checked first so it wins over a soft request.
  always_comb begin
    nxt = state;
    unique case (state)
      PLL_RST: begin
        if (cnt == PLL_END) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk)           nxt = STABILISE;
        else if (timeout) nxt = PLL_RST;
      end
      STABILISE: begin
        if (!lk)                 nxt = WAIT_LOCK;
        else if (cnt == STB_END) nxt = SDRAM_UP;
      end
      SDRAM_UP: begin
        if (!lk)                 nxt = PLL_RST;
        else if (cnt == S2C_END) nxt = RUN;
      end
      RUN: begin
        if (!lk)                     nxt = PLL_RST;
        else if (bus.soft_reset_req) nxt = SOFT_RST;
      end
      SOFT_RST: begin
        if (!lk)                 nxt = PLL_RST;
        else if (cnt == S2C_END) nxt = RUN;
      end
      default: nxt = PLL_RST;
    endcase
  end

  always_comb begin
    pll_n  = 1'b1;
    sd_n   = 1'b1;
    sys_n  = 1'b1;
    done_n = 1'b0;
    case (nxt)
      WAIT_LOCK, STABILISE: begin
        pll_n = 1'b0;
      end
      SDRAM_UP, SOFT_RST: begin
        pll_n = 1'b0;
        sd_n  = 1'b0;
      end
      RUN: begin
        pll_n  = 1'b0;
        sd_n   = 1'b0;
        sys_n  = 1'b0;
        done_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pll_rst     = pll_q;
  assign bus.sdram_reset = sd_q;
  assign bus.sys_reset   = sys_q;
  assign bus.reset_done  = done_q;

endmodule
